// File: rtl/pipe_latch_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and lock/flush controls.
// Optional statistics counters are built only when PIPE_LATCH_STATS_EN is defined.
module pipe_latch_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              lock_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              acc, emit;

  // Ready is derived from skid occupancy only, so it never depends on out_ready_i.
  assign in_ready_o  = !skid_v && !lock_i && !flush_i;
  assign out_valid_o = main_v && !lock_i && !flush_i;
  assign acc         = in_valid_i && in_ready_o;
  assign emit        = out_valid_o && out_ready_i;

  assign out_data_o = main_d;
  assign occ_o      = {skid_v, main_v ^ skid_v};

  // Lock needs no branch of its own: it forces acc and emit low, so every register holds.
  // NOTE: all state uses non-blocking assignments so each register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush_i) begin
      // Payload is cleared too, so out_data_o reads 0 after a flush.
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (!main_v) begin
      if (acc) begin
        main_v <= 1'b1;
        main_d <= in_data_i;
      end
    end else if (!skid_v) begin
      if (acc && emit) begin
        main_d <= in_data_i;
      end else if (acc) begin
        skid_v <= 1'b1;
        skid_d <= in_data_i;
      end else if (emit) begin
        main_v <= 1'b0;
      end
    end else if (emit) begin
      main_d <= skid_d;
      skid_v <= 1'b0;
    end
  end

`ifdef PIPE_LATCH_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_ev, flush_ev;

  assign stall_ev = main_v && !flush_i && (lock_i || !out_ready_i);
  assign flush_ev = flush_i && (main_v || skid_v);

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_latch_skid.md
# pipe_latch_skid

Parametrised pipeline stage register, the successor to the fixed-field inter-stage latches. It carries an opaque DATA_W-bit payload with a valid/ready handshake and a 2-entry skid buffer, so the stage sustains one transfer per cycle with registered upstream ready. It keeps the stage-level lock (hold) and flush (kill) controls used by the hazard unit. It sits between any two pipeline stages (IF/ID, ID/RR, RR/EX, …).

## Interface
- DATA_W, 32, payload width (instruction, PCs, control bits concatenated by the instantiator)
- CNT_W, 16, width of statistics counters
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous kill of all held entries
- lock_i  in  1  freeze stage: no accept, no emit, contents held
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  downstream payload valid
- out_ready_i  in  1  downstream can accept
- out_data_o  out  DATA_W  downstream payload (main register)
- occ_o  out  2  entries held: 0, 1 or 2
- stall_cnt_o  out  CNT_W  stall-cycle counter
- flush_cnt_o  out  CNT_W  effective-flush counter

## Operation
- Storage: main register (main_v, main_d) drives out_data_o; skid register (skid_v, skid_d). State is encoded by occupancy: EMPTY (0), ONE (main only), TWO (main + skid).
- in_ready_o = !skid_v & !lock_i & !flush_i.
- out_valid_o = main_v & !lock_i & !flush_i.
- acc = in_valid_i & in_ready_o.
- emit = out_valid_o & out_ready_i.
- Priority: reset > flush > lock > normal.
- Normal transitions:
  - EMPTY: acc → ONE, main_d ← in_data_i.
  - ONE: acc & emit → ONE, main_d ← in_data_i. acc & !emit → TWO, skid_d ← in_data_i. emit only → EMPTY. Neither → hold.
  - TWO: acc impossible. emit → ONE, main_d ← skid_d. No emit → hold.
- Flush: main_v, skid_v ← 0; main_d, skid_d ← 0. The occupancy after the flush cycle is 0. Handshakes are blocked that cycle, so nothing is accepted or emitted.
- Lock (without flush): all registers hold. in_ready_o = out_valid_o = 0.
- Payload is never reordered, duplicated or dropped except by flush.
- out_data_o is 0 whenever main_v = 0 after reset or flush. After a normal drain to EMPTY it retains its last value; consumers must qualify it with out_valid_o.
- occ_o = {skid_v, main_v ^ skid_v}. Equivalently: 0 → 0, main only → 1, both → 2.

## Timing
- Reset value of every output/register: in_ready_o = 1 once rst_ni deasserts, provided lock_i = flush_i = 0. out_valid_o = 0, out_data_o = 0, occ_o = 0, both counters = 0, skid_d = 0.
- Latency: accepted in cycle N → out_valid_o in cycle N+1 (when EMPTY, or when ONE with simultaneous emit).
- Throughput: 1 transfer/cycle with out_ready_i held high.
- in_ready_o depends combinationally only on skid_v, lock_i and flush_i, never on out_ready_i.
- Backpressure: out_ready_i low for one cycle while streaming absorbs exactly one beat into skid. in_ready_o drops the following cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). Entries held at that moment are lost.
- flush_i and lock_i together: flush wins.

## Configuration
- Macro: PIPE_LATCH_STATS_EN.
- Defined:
  - stall_cnt_o increments each cycle with main_v = 1 & flush_i = 0 & (lock_i = 1 | out_ready_i = 0).
  - flush_cnt_o increments each cycle with flush_i = 1 & (main_v | skid_v).
  - Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are generated. Handshake behaviour is identical.

## Test plan
- Stream: reset, out_ready_i = 1, inputs 0xA0..0xA7 on 8 consecutive cycles → out_data_o = 0xA0..0xA7 on cycles 1..8 after the first accept, in_ready_o constantly 1, occ_o = 1.
- Backpressure: while streaming 0xB0.., out_ready_i = 0 for 3 cycles → occ_o reaches 2, in_ready_o = 0 from the second stalled cycle. Output order is 0xB0, 0xB1, 0xB2… with no loss or duplicates. With STATS_EN, stall_cnt_o = 3.
- Flush at full: occ_o = 2 holding 0xC0, 0xC1, then flush_i for 1 cycle with in_valid_i = 1, in_data_i = 0xC2 → next cycle occ_o = 0, out_data_o = 0, 0xC2 not captured. With STATS_EN, flush_cnt_o = 1. A flush while EMPTY leaves flush_cnt_o unchanged.
- Lock: occ_o = 1 holding 0xD0, lock_i = 1 for 4 cycles with in_valid_i = out_ready_i = 1 → in_ready_o = out_valid_o = 0 and contents held. After release, 0xD0 is emitted next.
- Async reset mid-stream: assert rst_ni low between clock edges with occ_o = 2 → outputs go to reset values immediately. The first accepted beat after release appears alone.
- Saturation (STATS_EN, CNT_W = 4): hold out_ready_i = 0 with main_v = 1 for 20 cycles → stall_cnt_o = 0xF and stays there.
